ahb_ext_sram: RTL and testbench

AHB-Lite subordinate modelling external memory on the SoC's external bus window (selected by HSELEXT). It consumes the SoC's AHB manager outputs and produces HRDATAEXT/HREADYEXT/HRESPEXT. It replaces the constant tie-offs in lint and simulation wrappers. Wait states are programmable and byte-strobed writes are supported, so testbenches exercise real stall and response paths.

---
 rtl/ahb_ext_sram_pkg.sv | 25 ++
 rtl/ahb_ext_sram_if.sv | 27 ++
 rtl/ahb_ext_sram_array.sv | 28 ++
 rtl/ahb_ext_sram.sv | 134 +++++++++++++
 tb/tb_ahb_ext_sram.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_ext_sram_pkg.sv
// Shared types and constants for the external-bus AHB-Lite SRAM model.
package ahb_ext_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_DATA = 3'd2,
      ST_ERR1 = 3'd3,
      ST_ERR2 = 3'd4
   } sram_state_t;

   localparam int unsigned WAIT_CNT_W = 4;
   typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

endpackage

// File: rtl/ahb_ext_sram_if.sv
// AHB-Lite signal bundle between the SoC manager side and the external SRAM model.
interface ahb_ext_sram_if #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned ADDR_W = 34
);
   logic                HSEL;
   logic [ADDR_W-1:0]   HADDR;
   logic [DATA_W-1:0]   HWDATA;
   logic [DATA_W/8-1:0] HWSTRB;
   logic                HWRITE;
   logic [2:0]          HSIZE;
   logic [1:0]          HTRANS;
   logic                HREADY;
   logic [DATA_W-1:0]   HRDATA;
   logic                HREADYOUT;
   logic                HRESP;

   modport master (
      output HSEL, HADDR, HWDATA, HWSTRB, HWRITE, HSIZE, HTRANS, HREADY,
      input  HRDATA, HREADYOUT, HRESP
   );

   modport slave (
      input  HSEL, HADDR, HWDATA, HWSTRB, HWRITE, HSIZE, HTRANS, HREADY,
      output HRDATA, HREADYOUT, HRESP
   );
endinterface

// File: rtl/ahb_ext_sram_array.sv
// Word-wide storage with per-byte synchronous write and combinational read.
module ahb_ext_sram_array #(
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned MEM_WORDS = 4096
) (
   input  logic                         clk,
   input  logic                         we,
   input  logic [$clog2(MEM_WORDS)-1:0] idx,
   input  logic [DATA_W/8-1:0]          wstrb,
   input  logic [DATA_W-1:0]            wdata,
   output logic [DATA_W-1:0]            rdata_c
);
   localparam int unsigned STRB_W = DATA_W / 8;

   logic [DATA_W-1:0] mem [MEM_WORDS];

   // Byte-enabled write; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < int'(STRB_W); b++) begin
            if (wstrb[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   assign rdata_c = mem[idx];

endmodule

// File: rtl/ahb_ext_sram.sv
// AHB-Lite subordinate modelling external memory with programmable wait states.
// Optional: define AHB_EXT_SRAM_ERRRESP_EN to answer out-of-window accesses with
// a two-cycle ERROR response; otherwise the word index wraps modulo MEM_WORDS.
module ahb_ext_sram
   import ahb_ext_pkg::*;
#(
   parameter int unsigned       DATA_W      = 64,
   parameter int unsigned       ADDR_W      = 34,
   parameter int unsigned       MEM_WORDS   = 4096,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h8000_0000),
   parameter int unsigned       WAIT_STATES = 2
) (
   input  logic           HCLK,
   input  logic           HRESETn,
   ahb_ext_sram_if.slave  bus
);
   localparam int unsigned STRB_W    = DATA_W / 8;
   localparam int unsigned BYTE_SH   = $clog2(STRB_W);
   localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
   localparam wait_cnt_t   WAIT_LOAD = wait_cnt_t'(WAIT_STATES);

   sram_state_t       state_q;
   sram_state_t       state_d;
   sram_state_t       start_state_c;
   wait_cnt_t         cnt_q;
   logic [IDX_W-1:0]  idx_q;
   logic              write_q;
   logic [2:0]        size_q;

   logic [ADDR_W-1:0] offset_c;
   logic [IDX_W-1:0]  idx_c;
   logic              accept_c;
   logic              hready_c;
   logic              hresp_c;
   logic              we_c;
   logic              rd_en_c;
   logic [DATA_W-1:0] rdata_c;
   logic              unused_c;

   // Address decode: word index relative to the window base.
   assign offset_c = bus.HADDR - BASE_ADDR;
   assign idx_c    = offset_c[BYTE_SH +: IDX_W];
   assign accept_c = bus.HSEL & bus.HREADY & hready_c &
                     (bus.HTRANS inside {HTRANS_NONSEQ, HTRANS_SEQ});

`ifdef AHB_EXT_SRAM_ERRRESP_EN
   logic range_err_c;
   assign range_err_c   = (bus.HADDR < BASE_ADDR) | (|offset_c[ADDR_W-1:BYTE_SH+IDX_W]);
   assign start_state_c = range_err_c       ? ST_ERR1 :
                          (WAIT_STATES != 0) ? ST_WAIT : ST_DATA;
`else
   assign start_state_c = (WAIT_STATES != 0) ? ST_WAIT : ST_DATA;
`endif

   // Byte-lane bits, out-of-window bits and HSIZE are intentionally not decoded.
   assign unused_c = ^{offset_c[BYTE_SH-1:0], offset_c[ADDR_W-1:BYTE_SH+IDX_W], size_q};

   // State register.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Next-state: a new transfer may start whenever the bus sees us ready.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DATA: state_d = accept_c ? start_state_c : ST_IDLE;
         ST_WAIT:          if (cnt_q == wait_cnt_t'(1)) state_d = ST_DATA;
`ifdef AHB_EXT_SRAM_ERRRESP_EN
         ST_ERR1:          state_d = ST_ERR2;
         ST_ERR2:          state_d = accept_c ? start_state_c : ST_IDLE;
`endif
         default:          state_d = ST_IDLE;
      endcase
   end

   // Output decode from the current state.
   always_comb begin
      hready_c = 1'b1;
      hresp_c  = HRESP_OKAY;
      we_c     = 1'b0;
      rd_en_c  = 1'b0;
      case (state_q)
         ST_WAIT: hready_c = 1'b0;
         ST_DATA: begin
            we_c    = write_q;
            rd_en_c = ~write_q;
         end
`ifdef AHB_EXT_SRAM_ERRRESP_EN
         ST_ERR1: begin
            hready_c = 1'b0;
            hresp_c  = HRESP_ERROR;
         end
         ST_ERR2: hresp_c = HRESP_ERROR;
`endif
         default: ;
      endcase
   end

   // Address-phase capture and wait-state countdown.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         write_q <= 1'b0;
         size_q  <= '0;
      end else if (accept_c) begin
         cnt_q   <= WAIT_LOAD;
         idx_q   <= idx_c;
         write_q <= bus.HWRITE;
         size_q  <= bus.HSIZE;
      end else if (state_q == ST_WAIT) begin
         cnt_q   <= cnt_q - wait_cnt_t'(1);
      end
   end

   ahb_ext_sram_array #(
      .DATA_W    (DATA_W),
      .MEM_WORDS (MEM_WORDS)
   ) u_array (
      .clk     (HCLK),
      .we      (we_c),
      .idx     (idx_q),
      .wstrb   (bus.HWSTRB),
      .wdata   (bus.HWDATA),
      .rdata_c (rdata_c)
   );

   assign bus.HREADYOUT = hready_c;
   assign bus.HRESP     = hresp_c;
   assign bus.HRDATA    = rd_en_c ? rdata_c : '0;

endmodule

// File: tb/tb_ahb_ext_sram.sv
// Self-checking bench: two instances (2 and 0 wait states) against a word-array model.
module tb_ahb_ext_sram;
   localparam int unsigned DW = 64;
   localparam int unsigned AW = 34;
   localparam int unsigned MW = 4096;
   localparam logic [33:0] BASE = 34'h0_8000_0000;
   localparam logic [33:0] OOR  = 34'h0_8000_8000;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        hsel, hwrite, hready_en;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic [33:0] haddr;
   logic [63:0] hwdata;
   logic [7:0]  hwstrb;
   int          tgt;

   int checks = 0;
   int errors = 0;

   logic [63:0] mdl [2][MW];

   ahb_ext_sram_if #(.DATA_W(DW), .ADDR_W(AW)) bus_w2 ();
   ahb_ext_sram_if #(.DATA_W(DW), .ADDR_W(AW)) bus_w0 ();

   assign bus_w2.HSEL   = hsel & (tgt == 0);
   assign bus_w0.HSEL   = hsel & (tgt == 1);
   assign bus_w2.HADDR  = haddr;   assign bus_w0.HADDR  = haddr;
   assign bus_w2.HWDATA = hwdata;  assign bus_w0.HWDATA = hwdata;
   assign bus_w2.HWSTRB = hwstrb;  assign bus_w0.HWSTRB = hwstrb;
   assign bus_w2.HWRITE = hwrite;  assign bus_w0.HWRITE = hwrite;
   assign bus_w2.HSIZE  = hsize;   assign bus_w0.HSIZE  = hsize;
   assign bus_w2.HTRANS = htrans;  assign bus_w0.HTRANS = htrans;
   assign bus_w2.HREADY = bus_w2.HREADYOUT & hready_en;
   assign bus_w0.HREADY = bus_w0.HREADYOUT & hready_en;

   logic        obs_ready, obs_resp;
   logic [63:0] obs_rdata;
   assign obs_ready = (tgt == 0) ? bus_w2.HREADYOUT : bus_w0.HREADYOUT;
   assign obs_resp  = (tgt == 0) ? bus_w2.HRESP     : bus_w0.HRESP;
   assign obs_rdata = (tgt == 0) ? bus_w2.HRDATA    : bus_w0.HRDATA;

   ahb_ext_sram #(.DATA_W(DW), .ADDR_W(AW), .MEM_WORDS(MW), .BASE_ADDR(BASE), .WAIT_STATES(2))
      u_w2 (.HCLK(clk), .HRESETn(rst_n), .bus(bus_w2));
   ahb_ext_sram #(.DATA_W(DW), .ADDR_W(AW), .MEM_WORDS(MW), .BASE_ADDR(BASE), .WAIT_STATES(0))
      u_w0 (.HCLK(clk), .HRESETn(rst_n), .bus(bus_w0));

   // Word index as the window arithmetic defines it, wrapping modulo the depth.
   function automatic int exp_idx(input logic [33:0] a);
      logic [33:0] off;
      off = a - BASE;
      return int'((off / 34'd8) % 34'(MW));
   endfunction

   task automatic mdl_write(input int t, input int i, input logic [63:0] wd, input logic [7:0] st);
      for (int b = 0; b < 8; b++) if (st[b]) mdl[t][i][b*8 +: 8] = wd[b*8 +: 8];
   endtask

   // One isolated transfer; starts and ends just after a rising edge.
   task automatic single(input int t, input bit wr, input logic [33:0] a, input logic [63:0] wd,
                         input logic [7:0] st, output logic [63:0] rd, output int nlow,
                         output int nresp, output int nbad, output bit to);
      tgt = t; hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = wr; hsize = 3'd3;
      @(posedge clk); #1;
      hsel = 1'b0; htrans = 2'b00; hwdata = wd; hwstrb = st;
      nlow = 0; nresp = 0; nbad = 0; rd = '0; to = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (obs_resp) nresp++;
         if (obs_ready) begin
            rd = obs_rdata; to = 1'b0;
            break;
         end
         nlow++;
         if (obs_rdata !== 64'd0) nbad++;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      hwstrb = 8'h00;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if ({bus_w2.HREADYOUT, bus_w2.HRESP, bus_w2.HRDATA, bus_w0.HREADYOUT, bus_w0.HRESP, bus_w0.HRDATA}
             !== {1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 64'd0}) begin
            errors++;
            $display("FAIL reset_hold cyc=%0d got w2 rdy=%b resp=%b rd=%h w0 rdy=%b resp=%b rd=%h exp rdy=1 resp=0 rd=0",
                     c, bus_w2.HREADYOUT, bus_w2.HRESP, bus_w2.HRDATA, bus_w0.HREADYOUT, bus_w0.HRESP, bus_w0.HRDATA);
         end
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if ({bus_w2.HREADYOUT, bus_w2.HRESP, bus_w2.HRDATA, bus_w0.HREADYOUT, bus_w0.HRESP, bus_w0.HRDATA}
             !== {1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 64'd0}) begin
            errors++;
            $display("FAIL reset_release cyc=%0d got w2 rdy=%b resp=%b rd=%h w0 rdy=%b resp=%b rd=%h exp rdy=1 resp=0 rd=0",
                     c, bus_w2.HREADYOUT, bus_w2.HRESP, bus_w2.HRDATA, bus_w0.HREADYOUT, bus_w0.HRESP, bus_w0.HRDATA);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_wait_states();
      logic [63:0] rd; int nl, nr, nb; bit to;
      single(0, 1'b1, 34'h0_8000_0010, 64'h1122334455667788, 8'hFF, rd, nl, nr, nb, to);
      mdl_write(0, exp_idx(34'h0_8000_0010), 64'h1122334455667788, 8'hFF);
      checks++;
      if (to || nl != 2 || nr != 0 || rd !== 64'd0) begin
         errors++;
         $display("FAIL ws2_write got low=%0d resp=%0d rd=%h to=%0d exp low=2 resp=0 rd=0", nl, nr, rd, to);
      end
      single(0, 1'b0, 34'h0_8000_0010, 64'd0, 8'hFF, rd, nl, nr, nb, to);
      checks++;
      if (to || nl != 2 || nr != 0 || nb != 0 || rd !== 64'h1122334455667788) begin
         errors++;
         $display("FAIL ws2_read got low=%0d resp=%0d bad=%0d rd=%h exp low=2 resp=0 rd=1122334455667788", nl, nr, nb, rd);
      end
   endtask

   task automatic test_partial_write();
      logic [63:0] rd; int nl, nr, nb; bit to;
      single(0, 1'b1, 34'h0_8000_0013, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, rd, nl, nr, nb, to);
      mdl_write(0, exp_idx(34'h0_8000_0010), 64'hAAAAAAAA_BBBBBBBB, 8'h0F);
      single(0, 1'b0, 34'h0_8000_0010, 64'd0, 8'h00, rd, nl, nr, nb, to);
      checks++;
      if (to || rd !== 64'h11223344_BBBBBBBB) begin
         errors++;
         $display("FAIL partial_write got rd=%h to=%0d exp 11223344bbbbbbbb", rd, to);
      end
      single(0, 1'b1, 34'h0_8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, rd, nl, nr, nb, to);
      single(0, 1'b0, 34'h0_8000_0010, 64'd0, 8'h00, rd, nl, nr, nb, to);
      checks++;
      if (to || rd !== 64'h11223344_BBBBBBBB) begin
         errors++;
         $display("FAIL zero_strobe got rd=%h exp 11223344bbbbbbbb", rd);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] v, rd; int nl, nr, nb; bit to;
      v = {$urandom, $urandom};
      tgt = 1; hsel = 1'b1; htrans = 2'b10; haddr = 34'h0_8000_0020; hwrite = 1'b1; hsize = 3'd3;
      @(posedge clk); #1;
      hwdata = v; hwstrb = 8'hFF; hwrite = 1'b0;
      @(negedge clk);
      checks++;
      if (obs_ready !== 1'b1 || obs_resp !== 1'b0) begin
         errors++;
         $display("FAIL b2b_write_phase got rdy=%b resp=%b exp rdy=1 resp=0", obs_ready, obs_resp);
      end
      @(posedge clk); #1;
      mdl_write(1, exp_idx(34'h0_8000_0020), v, 8'hFF);
      hsel = 1'b0; htrans = 2'b00; hwdata = ~v;
      @(negedge clk);
      checks++;
      if (obs_ready !== 1'b1 || obs_rdata !== v) begin
         errors++;
         $display("FAIL b2b_read_phase got rdy=%b rd=%h exp rdy=1 rd=%h", obs_ready, obs_rdata, v);
      end
      @(posedge clk); #1;
      hwstrb = 8'h00;
      single(1, 1'b0, 34'h0_8000_0020, 64'd0, 8'h00, rd, nl, nr, nb, to);
      checks++;
      if (to || nl != 0 || rd !== v) begin
         errors++;
         $display("FAIL b2b_reread got low=%0d rd=%h exp low=0 rd=%h", nl, rd, v);
      end
   endtask

   task automatic test_hready_low();
      logic [63:0] v, rd; int nl, nr, nb; bit to, bad;
      v = {$urandom, $urandom};
      single(0, 1'b1, 34'h0_8000_0038, v, 8'hFF, rd, nl, nr, nb, to);
      mdl_write(0, 7, v, 8'hFF);
      hready_en = 1'b0; tgt = 0; bad = 1'b0;
      hsel = 1'b1; htrans = 2'b10; haddr = 34'h0_8000_0038; hwrite = 1'b1; hwdata = ~v; hwstrb = 8'hFF;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (obs_ready !== 1'b1 || obs_resp !== 1'b0 || obs_rdata !== 64'd0) bad = 1'b1;
         @(posedge clk); #1;
      end
      hsel = 1'b0; htrans = 2'b00; hready_en = 1'b1;
      repeat (4) @(posedge clk);
      #1; hwstrb = 8'h00;
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL hready_low_outputs got non-idle response exp rdy=1 resp=0 rd=0");
      end
      single(0, 1'b0, 34'h0_8000_0038, 64'd0, 8'h00, rd, nl, nr, nb, to);
      checks++;
      if (to || rd !== mdl[0][7]) begin
         errors++;
         $display("FAIL hready_low_no_write got rd=%h exp %h", rd, mdl[0][7]);
      end
   endtask

   task automatic test_range();
      logic [63:0] v, w, rd; int nl, nr, nb; bit to;
      v = {$urandom, $urandom};
      w = {$urandom, $urandom};
      single(0, 1'b1, BASE, v, 8'hFF, rd, nl, nr, nb, to);
      mdl_write(0, 0, v, 8'hFF);
`ifdef AHB_EXT_SRAM_ERRRESP_EN
      single(0, 1'b0, OOR, 64'd0, 8'h00, rd, nl, nr, nb, to);
      checks++;
      if (to || nl != 1 || nr != 2 || rd !== 64'd0) begin
         errors++;
         $display("FAIL oor_read got low=%0d resp=%0d rd=%h exp low=1 resp=2 rd=0", nl, nr, rd);
      end
      single(0, 1'b1, OOR, w, 8'hFF, rd, nl, nr, nb, to);
      checks++;
      if (to || nl != 1 || nr != 2) begin
         errors++;
         $display("FAIL oor_write got low=%0d resp=%0d exp low=1 resp=2", nl, nr);
      end
      single(0, 1'b1, 34'h0_7FFF_FFF8, w, 8'hFF, rd, nl, nr, nb, to);
      checks++;
      if (to || nl != 1 || nr != 2) begin
         errors++;
         $display("FAIL below_base got low=%0d resp=%0d exp low=1 resp=2", nl, nr);
      end
`else
      single(0, 1'b0, OOR, 64'd0, 8'h00, rd, nl, nr, nb, to);
      checks++;
      if (to || nl != 2 || nr != 0 || rd !== mdl[0][exp_idx(OOR)]) begin
         errors++;
         $display("FAIL oor_alias_read got low=%0d resp=%0d rd=%h exp low=2 resp=0 rd=%h", nl, nr, rd, mdl[0][exp_idx(OOR)]);
      end
      single(0, 1'b1, OOR, w, 8'hFF, rd, nl, nr, nb, to);
      mdl_write(0, exp_idx(OOR), w, 8'hFF);
      checks++;
      if (to || nr != 0) begin
         errors++;
         $display("FAIL oor_alias_write got resp=%0d to=%0d exp resp=0", nr, to);
      end
      single(0, 1'b1, 34'h0_7FFF_FFF8, ~w, 8'hFF, rd, nl, nr, nb, to);
      mdl_write(0, exp_idx(34'h0_7FFF_FFF8), ~w, 8'hFF);
      single(0, 1'b0, 34'h0_7FFF_FFF8, 64'd0, 8'h00, rd, nl, nr, nb, to);
      checks++;
      if (to || nr != 0 || rd !== mdl[0][MW-1]) begin
         errors++;
         $display("FAIL below_base_wrap got rd=%h resp=%0d exp rd=%h resp=0", rd, nr, mdl[0][MW-1]);
      end
`endif
      single(0, 1'b0, BASE, 64'd0, 8'h00, rd, nl, nr, nb, to);
      checks++;
      if (to || rd !== mdl[0][0]) begin
         errors++;
         $display("FAIL range_word0 got rd=%h exp %h", rd, mdl[0][0]);
      end
   endtask

   task automatic test_reset_mid();
      logic [63:0] v, rd; int nl, nr, nb; bit to;
      v = {$urandom, $urandom};
      single(0, 1'b1, 34'h0_8000_0028, v, 8'hFF, rd, nl, nr, nb, to);
      mdl_write(0, 5, v, 8'hFF);
      tgt = 0; hsel = 1'b1; htrans = 2'b10; haddr = 34'h0_8000_0028; hwrite = 1'b1;
      @(posedge clk); #1;
      hsel = 1'b0; htrans = 2'b00; hwdata = ~v; hwstrb = 8'hFF;
      @(negedge clk);
      checks++;
      if (obs_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_stall got rdy=%b exp 0", obs_ready);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs_ready !== 1'b1 || obs_resp !== 1'b0 || obs_rdata !== 64'd0) begin
         errors++;
         $display("FAIL reset_mid_outputs got rdy=%b resp=%b rd=%h exp rdy=1 resp=0 rd=0", obs_ready, obs_resp, obs_rdata);
      end
      repeat (2) @(posedge clk);
      #1; rst_n = 1'b1; hwstrb = 8'h00;
      @(posedge clk); #1;
      single(0, 1'b0, 34'h0_8000_0028, 64'd0, 8'h00, rd, nl, nr, nb, to);
      checks++;
      if (to || rd !== v) begin
         errors++;
         $display("FAIL reset_mid_word5 got rd=%h exp %h", rd, v);
      end
   endtask

   // Random pipelined traffic with idle gaps; first 16 ops initialise words 0..15.
   task automatic test_random(input int t, input int nops);
      bit a_v, a_wr, d_v, d_wr, rdy;
      int a_idx, d_idx, stalls, issued, guard, ws;
      logic [63:0] a_wd, d_wd, expv;
      logic [7:0]  a_st, d_st;
      logic [2:0]  a_lo;
      ws = (t == 0) ? 2 : 0;
      a_v = 1'b0; d_v = 1'b0; a_wr = 1'b0; d_wr = 1'b0;
      a_idx = 0; d_idx = 0; a_wd = '0; d_wd = '0; a_st = '0; d_st = '0; a_lo = '0;
      stalls = 0; issued = 0; guard = 0;
      while ((issued < nops || a_v || d_v) && guard < 3000) begin
         guard++;
         if (!a_v && issued < nops && $urandom_range(3) != 0) begin
            a_v   = 1'b1;
            a_wr  = (issued < 16) ? 1'b1 : 1'($urandom_range(1));
            a_idx = (issued < 16) ? issued : int'($urandom_range(15));
            a_wd  = {$urandom, $urandom};
            a_st  = (issued < 16) ? 8'hFF : 8'($urandom);
            a_lo  = 3'($urandom);
            issued++;
         end
         tgt = t; hsel = a_v; htrans = a_v ? 2'b10 : 2'b00;
         haddr = BASE + 34'(a_idx * 8) + 34'(a_lo);
         hwrite = a_wr; hsize = 3'($urandom);
         hwdata = d_v ? d_wd : 64'd0;
         hwstrb = d_v ? d_st : 8'h00;
         @(negedge clk);
         rdy = obs_ready;
         if (d_v) begin
            if (!rdy) stalls++;
            else begin
               expv = d_wr ? 64'd0 : mdl[t][d_idx];
               checks++;
               if (stalls != ws || obs_rdata !== expv || obs_resp !== 1'b0) begin
                  errors++;
                  $display("FAIL rand_t%0d wr=%0d idx=%0d got stalls=%0d rd=%h resp=%b exp stalls=%0d rd=%h resp=0",
                           t, d_wr, d_idx, stalls, obs_rdata, obs_resp, ws, expv);
               end
               if (d_wr) mdl_write(t, d_idx, d_wd, d_st);
            end
         end
         @(posedge clk); #1;
         if (rdy) begin
            d_v = a_v; d_wr = a_wr; d_idx = a_idx; d_wd = a_wd; d_st = a_st;
            a_v = 1'b0; stalls = 0;
         end
      end
      hsel = 1'b0; htrans = 2'b00; hwstrb = 8'h00;
      checks++;
      if (guard >= 3000) begin
         errors++;
         $display("FAIL rand_t%0d_timeout got guard=%0d exp completion", t, guard);
      end
   endtask

   initial begin
      rst_n = 1'b0; hsel = 1'b0; hwrite = 1'b0; hready_en = 1'b1; htrans = 2'b00;
      hsize = 3'd0; haddr = '0; hwdata = '0; hwstrb = '0; tgt = 0;
      test_reset();
      test_wait_states();
      test_partial_write();
      test_back_to_back();
      test_hready_low();
      test_range();
      test_reset_mid();
      test_random(0, 80);
      test_random(1, 80);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got no completion exp finish");
      $fatal(1, "watchdog");
   end

endmodule
